// File: rtl/button_irq_ctrl.sv
// -----------------------------------------------------------------------------
// button_irq_ctrl
//   Push-button conditioner and prioritised interrupt source.
//   Each raw button goes through a 2-flop synchroniser and a counter-based
//   debouncer. Each debounced rising edge on an enabled channel latches a
//   pending bit. A two-state arbiter raises one request for the lowest-index
//   pending channel and keeps it until the handler acks it.
//
//   Ports
//     clk, rst     : clock, synchronous active-high reset
//     btn_raw      : asynchronous raw button levels, 1 = pressed
//     en_mask      : per-channel interrupt enable
//     irq_ack      : one-cycle acknowledge from the handler
//     irq, irq_id  : level request and the channel it refers to
//     pending      : latched presses not yet acknowledged
//     overrun      : sticky, a press arrived while the channel was pending
//     btn_state    : debounced button levels
//     dbg_state    : arbiter state (0 = IDLE, 1 = REQ)
//
//   Handshake: irq is a level that rises one cycle after the arbiter sees a
//   pending bit in IDLE. irq_id is stable for the whole time irq=1. The
//   request retires on the edge where irq_ack=1 is sampled with irq=1; irq
//   then stays low for exactly one cycle before any next request. irq_ack
//   sampled while irq=0 has no effect.
// -----------------------------------------------------------------------------
module button_irq_ctrl #(
  parameter int NUM_BTN         = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10,
  parameter int ID_W            = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] en_mask,
  input  logic               irq_ack,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_BTN-1:0] pending,
  output logic [NUM_BTN-1:0] overrun,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} arb_state_t;

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] btn_state_q, btn_state_d;
  logic [NUM_BTN-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] overrun_q, overrun_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  arb_state_t         state_q, state_d;

  logic [NUM_BTN-1:0] press;
  logic [ID_W-1:0]    lowest_id;
  logic               ack_clr;

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    btn_state_d = btn_state_q;
    btn_prev_d  = btn_state_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == btn_state_q[i]) begin
        // Any return to the accepted level restarts the stability count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        btn_state_d[i] = sync2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Registered compare: a press is a debounced 0->1 seen one cycle after it.
  assign press = btn_state_q & ~btn_prev_q;

  // ---------------------------------------------------------------------------
  // Pending / overrun
  // ---------------------------------------------------------------------------
  assign ack_clr = (state_q == S_REQ) && irq_ack;

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (ack_clr && (irq_id_q == ID_W'(i))) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
        // Set wins over the ack clear; the press is not counted as overrun
        // because the old request is being retired in this same cycle.
        if (press[i] && en_mask[i]) pending_d[i] = 1'b1;
      end else if (press[i] && en_mask[i]) begin
        if (pending_q[i]) overrun_d[i] = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    lowest_id = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d  = S_REQ;
          irq_id_d = lowest_id;
        end
      end
      S_REQ: begin
        if (irq_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    irq       = (state_q == S_REQ);
    dbg_state = state_q;
  end

  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign btn_state = btn_state_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      btn_state_q <= '0;
      btn_prev_q  <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      irq_id_q    <= '0;
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      btn_state_q <= btn_state_d;
      btn_prev_q  <= btn_prev_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      irq_id_q    <= irq_id_d;
      state_q     <= state_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_button_irq_ctrl.sv
module tb_button_irq_ctrl;

  localparam int NB  = 8;
  localparam int DEB = 4;
  localparam int IDW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] en_mask;
  logic          irq_ack;
  logic          irq;
  logic [IDW-1:0] irq_id;
  logic [NB-1:0] pending;
  logic [NB-1:0] overrun;
  logic [NB-1:0] btn_state;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;

  logic [IDW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  button_irq_ctrl #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .CNT_W(2), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .en_mask(en_mask),
    .irq_ack(irq_ack), .irq(irq), .irq_id(irq_id), .pending(pending),
    .overrun(overrun), .btn_state(btn_state), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL %s: irq=%0b after %0d cycles, expected 1", name, irq, budget);
    end
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (irq === 1'b1 && irq_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_irq: got irq_id %0d expected no request", irq_id);
      end else begin
        logic [IDW-1:0] e;
        e = exp_q.pop_front();
        if (irq_id !== e) begin
          errors++;
          $display("FAIL irq_id: got %0d expected %0d", irq_id, e);
        end
      end
    end
    irq_prev <= irq;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; btn_raw = '0; en_mask = '1; irq_ack = 1'b0;
    tick(2);
    rst = 1'b0;

    // 1. idle after reset
    tick(20);
    check("idle_irq", 32'(irq), 32'd0);
    check("idle_pending", 32'(pending), 32'h00);
    check("idle_btn_state", 32'(btn_state), 32'h00);
    check("idle_overrun", 32'(overrun), 32'h00);

    // 2. single press on channel 3, exact latencies
    exp_q.push_back(3'd3);
    btn_raw[3] = 1'b1;
    tick(5);
    check("c2_state_cyc5", 32'(btn_state), 32'h00);
    tick();
    check("c2_state_cyc6", 32'(btn_state), 32'h08);
    check("c2_pending_cyc6", 32'(pending), 32'h00);
    tick();
    check("c2_pending_cyc7", 32'(pending), 32'h08);
    check("c2_irq_cyc7", 32'(irq), 32'd0);
    tick();
    check("c2_irq_cyc8", 32'(irq), 32'd1);
    tick(3);
    check("c2_irq_held", 32'(irq), 32'd1);
    ack();
    check("c2_irq_after_ack", 32'(irq), 32'd0);
    check("c2_pending_after_ack", 32'(pending), 32'h00);
    btn_raw[3] = 1'b0;
    tick(10);
    check("c2_release_no_irq", 32'(irq), 32'd0);
    check("c2_release_state", 32'(btn_state), 32'h00);

    // 3. glitching channel 2 never debounces
    for (int k = 0; k < 4; k++) begin
      btn_raw[2] = (k % 2 == 0);
      tick();
    end
    btn_raw[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("c3_state", 32'(btn_state[2]), 32'd0);
    end
    check("c3_irq", 32'(irq), 32'd0);

    // 4. simultaneous presses on 5 and 1, ascending service order
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd5);
    btn_raw[5] = 1'b1; btn_raw[1] = 1'b1;
    wait_irq("c4_first", 20);
    check("c4_pending_both", 32'(pending), 32'h22);
    ack();
    check("c4_gap_irq", 32'(irq), 32'd0);
    check("c4_pending_after_first", 32'(pending), 32'h20);
    tick();
    check("c4_second_irq", 32'(irq), 32'd1);
    ack();
    check("c4_pending_done", 32'(pending), 32'h00);
    btn_raw[5] = 1'b0; btn_raw[1] = 1'b0;
    tick(10);

    // 5. overrun on channel 4
    exp_q.push_back(3'd4);
    btn_raw[4] = 1'b1;
    wait_irq("c5_irq", 20);
    btn_raw[4] = 1'b0;
    tick(8);
    check("c5_no_overrun_on_release", 32'(overrun), 32'h00);
    btn_raw[4] = 1'b1;
    tick(8);
    check("c5_overrun", 32'(overrun), 32'h10);
    check("c5_pending", 32'(pending), 32'h10);
    check("c5_irq_held", 32'(irq), 32'd1);
    ack();
    check("c5_overrun_cleared", 32'(overrun), 32'h00);
    check("c5_pending_cleared", 32'(pending), 32'h00);
    tick(2);
    check("c5_no_rerequest", 32'(irq), 32'd0);
    btn_raw[4] = 1'b0;
    tick(10);

    // 6a. masked channel 0 press is dropped
    en_mask = 8'hFE;
    btn_raw[0] = 1'b1;
    tick(10);
    check("c6a_state", 32'(btn_state), 32'h01);
    check("c6a_pending", 32'(pending), 32'h00);
    check("c6a_irq", 32'(irq), 32'd0);
    btn_raw[0] = 1'b0;
    tick(8);
    en_mask = 8'hFF;

    // 6b. reset during REQ with button held, then re-request
    exp_q.push_back(3'd6);
    btn_raw[6] = 1'b1;
    wait_irq("c6b_irq", 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("c6b_rst_irq", 32'(irq), 32'd0);
    check("c6b_rst_pending", 32'(pending), 32'h00);
    check("c6b_rst_state", 32'(btn_state), 32'h00);
    exp_q.push_back(3'd6);
    wait_irq("c6b_rerequest", 20);
    ack();
    check("c6b_pending_done", 32'(pending), 32'h00);
    btn_raw[6] = 1'b0;
    tick(10);

    // 7. ack coinciding with a new press on the same channel: set wins
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd7);
    btn_raw[7] = 1'b1;
    wait_irq("c7_irq", 20);
    btn_raw[7] = 1'b0;
    tick(8);
    btn_raw[7] = 1'b1;
    tick(6);
    check("c7_state_rose", 32'(btn_state[7]), 32'd1);
    ack();
    check("c7_pending_kept", 32'(pending), 32'h80);
    check("c7_overrun_clear", 32'(overrun), 32'h00);
    check("c7_gap", 32'(irq), 32'd0);
    tick();
    check("c7_rerequest", 32'(irq), 32'd1);
    ack();
    check("c7_pending_done", 32'(pending), 32'h00);
    btn_raw[7] = 1'b0;
    tick(10);

    // ---------------- final report ----------------
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_irq: %0d requests outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_irq_ctrl.md
Name: button_irq_ctrl

Overview:
Parametrised push-button conditioner and interrupt source for the board buttons (pb0..pb4, eq0..eq2 today), replacing per-button ad-hoc logic.
- Each of NUM_BTN raw inputs is synchronised and debounced, then rising-edge detected.
- Each press latches as a pending interrupt; one prioritised request with channel ID goes to the processor's interrupt unit.
- A request is retired by a one-cycle ack from the handler.

Parameters:
NUM_BTN, 8, number of button channels (1..16)
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised cycles required to accept a level change (>=2)
CNT_W, 10, debounce counter width; must hold DEBOUNCE_CYCLES-1
ID_W, 3, width of irq_id; must satisfy 2^ID_W >= NUM_BTN

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
btn_raw  input  NUM_BTN  asynchronous raw button levels, 1 = pressed
en_mask  input  NUM_BTN  per-channel interrupt enable, 1 = enabled
irq_ack  input  1  handler acknowledge, one-cycle pulse
irq  output  1  interrupt request, level
irq_id  output  ID_W  channel being requested, valid while irq=1
pending  output  NUM_BTN  latched, not-yet-acknowledged presses
overrun  output  NUM_BTN  sticky: a press arrived while that channel was already pending
btn_state  output  NUM_BTN  debounced button levels

Behaviour:
- Reset (rst=1 at a clk edge): synchroniser flops, debounce counters, btn_state, pending, overrun, irq and irq_id all go to 0. This applies equally mid-debounce or mid-handshake; no event survives reset.
- Synchroniser: two flops per channel; sync[i] is btn_raw[i] delayed by 2 cycles.
- Debounce, per channel:
  - If sync[i] == btn_state[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1 and sync still differs, btn_state[i] <= sync[i] and cnt[i] <= 0.
  - Any glitch back to btn_state restarts the count.
  - Raw edge to btn_state change = 2 + DEBOUNCE_CYCLES cycles.
- Press event: btn_state[i] 0->1 (registered compare). Releases generate no event.
- Pending set: a press with en_mask[i]=1 sets pending[i] on the next edge. A press with en_mask[i]=0 is dropped.
  - Clearing en_mask does not clear an existing pending bit.
- Overrun: a press on an enabled channel whose pending[i] is already 1 sets overrun[i]; pending stays 1.
- Arbiter, two-state FSM:
  - IDLE: irq=0. If any pending bit is 1, latch the lowest-index pending channel into irq_id, assert irq, go to REQ. Latency from pending set to irq = 1 cycle.
  - REQ: irq=1; irq_id is frozen. Newly pending higher-priority channels do not preempt.
  - On irq_ack=1 in REQ: clear pending[irq_id] and overrun[irq_id], deassert irq, return to IDLE.
  - Re-arbitration happens in IDLE, so consecutive requests are separated by exactly one irq=0 cycle.
  - irq_ack in IDLE is ignored.
- Ack coinciding with a new press on the same channel: set wins. pending stays 1, overrun is cleared, and that channel requests again after the one-cycle gap. No press is lost.
- Simultaneous presses on several channels: all pending bits set in the same cycle; they are served in ascending index order.
- irq_id is held (not zeroed) in IDLE; it is only meaningful while irq=1.

Test Plan:
All scenarios use the bench parameters DEBOUNCE_CYCLES=4, NUM_BTN=8.
1. Reset, then btn_raw=8'h00 for 20 cycles -> irq=0, pending=0, btn_state=0, overrun=0.
2. btn_raw[3] held 1 from cycle 0:
   - btn_state[3]=1 at cycle 6, pending=8'h08 at cycle 7, irq=1 with irq_id=3 at cycle 8.
   - irq_ack pulse -> irq=0 next cycle, pending=0.
3. btn_raw[2] toggles 1,0,1,0 on alternate cycles, then returns to 0 -> btn_state[2] never rises; irq stays 0.
4. btn_raw[5] and btn_raw[1] pressed in the same cycle:
   - First request has irq_id=1. Ack it -> one cycle irq=0, then irq=1 with irq_id=5.
   - Ack it -> pending=0.
5. Channel 4 pressed, released and pressed again before ack (each debounced) -> overrun[4]=1 with pending[4]=1. Ack -> both 0.
6. Mask and reset cases:
   - en_mask=8'hFE, press channel 0 -> pending stays 0.
   - Assert rst during REQ with irq_id=6 -> next cycle irq=0, pending=0, btn_state=0 even with button still held. Button still held -> re-debounces and requests again.
